// File: rtl/mesh_traffic_checker.sv
// Mesh endpoint test client: stores a seeded pattern to a remote tile, reads it
// back with a bounded number of pipelined loads, and flags any bad response.
module mesh_traffic_checker #(
    parameter int          x_cord_width_p  = 2,
    parameter int          y_cord_width_p  = 2,
    parameter int          data_width_p    = 32,
    parameter int          addr_width_p    = 10,
    parameter int          load_id_width_p = 11,
    parameter int          num_words_p     = 16,
    parameter int          max_out_p       = 4,
    parameter int          dest_x_p        = 1,
    parameter int          dest_y_p        = 1,
    parameter logic [31:0] seed_p          = 32'hA5A5_0000
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    output logic                       req_v_o,
    input  logic                       req_ready_i,
    output logic                       req_op_o,
    output logic [addr_width_p-1:0]    req_addr_o,
    output logic [data_width_p-1:0]    req_data_o,
    output logic [x_cord_width_p-1:0]  req_x_o,
    output logic [y_cord_width_p-1:0]  req_y_o,
    output logic [load_id_width_p-1:0] req_load_id_o,
    input  logic                       resp_v_i,
    input  logic [data_width_p-1:0]    resp_data_i,
    input  logic [load_id_width_p-1:0] resp_load_id_i,
    output logic                       finish_o,
    output logic                       error_o
);

    localparam int out_w = $clog2(max_out_p + 1);
    localparam int rsp_w = $clog2(num_words_p + 1);
    localparam logic [addr_width_p-1:0]  last_addr = addr_width_p'(num_words_p - 1);
    localparam logic [out_w-1:0]         max_out   = out_w'(max_out_p);
    localparam logic [rsp_w-1:0]         num_words = rsp_w'(num_words_p);
    localparam logic [load_id_width_p:0] tag_limit = (load_id_width_p + 1)'(num_words_p);

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [data_width_p-1:0] pattern(input logic [addr_width_p-1:0] a);
        return data_width_p'(a) ^ data_width_p'(seed_p);
    endfunction

    state_t                    state, state_next;
    logic [addr_width_p-1:0]   addr, addr_next;
    logic [out_w-1:0]          out_cnt, out_cnt_next;
    logic [rsp_w-1:0]          rsp_cnt, rsp_cnt_next;
    logic                      xfer;
    logic                      load_xfer;
    logic                      resp_ok;
    logic                      resp_bad;

    assign xfer      = req_v_o & req_ready_i;
    assign load_xfer = xfer & (state == LOAD);

    // A response only counts against an outstanding load; anything else is stray.
    assign resp_ok  = resp_v_i & (out_cnt != '0);
    assign resp_bad = resp_v_i & ((out_cnt == '0) |
                                  ({1'b0, resp_load_id_i} >= tag_limit) |
                                  (resp_data_i != pattern(resp_load_id_i[addr_width_p-1:0])));

    always_comb begin
        out_cnt_next = out_cnt;
        if (load_xfer && !resp_ok) begin
            out_cnt_next = out_cnt + out_w'(1);
        end else if (!load_xfer && resp_ok) begin
            out_cnt_next = out_cnt - out_w'(1);
        end
    end

    assign rsp_cnt_next = rsp_cnt + rsp_w'(resp_ok);

    assign req_addr_o    = addr;
    assign req_load_id_o = load_id_width_p'(addr);
    assign req_x_o       = x_cord_width_p'(dest_x_p);
    assign req_y_o       = y_cord_width_p'(dest_y_p);
    assign finish_o      = (state == DONE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            addr    <= '0;
            out_cnt <= '0;
            rsp_cnt <= '0;
            error_o <= 1'b0;
        end else begin
            state   <= state_next;
            addr    <= addr_next;
            out_cnt <= out_cnt_next;
            rsp_cnt <= rsp_cnt_next;
            error_o <= error_o | resp_bad;
        end
    end

    // DRAIN looks at next-cycle counts so finish_o rises one cycle after the last response.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        req_v_o    = 1'b0;
        req_op_o   = 1'b0;
        req_data_o = '0;
        unique case (state)
            IDLE: begin
                if (en_i) begin
                    state_next = STORE;
                    addr_next  = '0;
                end
            end
            STORE: begin
                req_v_o    = 1'b1;
                req_data_o = pattern(addr);
                if (xfer) begin
                    if (addr == last_addr) begin
                        state_next = LOAD;
                        addr_next  = '0;
                    end else begin
                        addr_next = addr + addr_width_p'(1);
                    end
                end
            end
            LOAD: begin
                req_v_o  = (out_cnt < max_out);
                req_op_o = 1'b1;
                if (xfer) begin
                    if (addr == last_addr) begin
                        state_next = DRAIN;
                    end else begin
                        addr_next = addr + addr_width_p'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_cnt_next == '0 && rsp_cnt_next == num_words) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mesh_traffic_checker.sv
// Randomized scoreboard bench for mesh_traffic_checker: a remote-memory model
// answers loads with selectable delay/order/corruption while a monitor checks requests.
module tb_mesh_traffic_checker;

    localparam int          N       = 16;
    localparam int          MAX_OUT = 4;
    localparam int          AW      = 10;
    localparam int          DW      = 32;
    localparam int          IDW     = 11;
    localparam logic [31:0] SEED    = 32'hA5A5_0000;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           en_i;
    logic           req_v_o;
    logic           req_ready_i;
    logic           req_op_o;
    logic [AW-1:0]  req_addr_o;
    logic [DW-1:0]  req_data_o;
    logic [1:0]     req_x_o;
    logic [1:0]     req_y_o;
    logic [IDW-1:0] req_load_id_o;
    logic           resp_v_i;
    logic [DW-1:0]  resp_data_i;
    logic [IDW-1:0] resp_load_id_i;
    logic           finish_o;
    logic           error_o;

    mesh_traffic_checker #(
        .x_cord_width_p (2),
        .y_cord_width_p (2),
        .data_width_p   (DW),
        .addr_width_p   (AW),
        .load_id_width_p(IDW),
        .num_words_p    (N),
        .max_out_p      (MAX_OUT),
        .dest_x_p       (1),
        .dest_y_p       (1),
        .seed_p         (SEED)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .en_i          (en_i),
        .req_v_o       (req_v_o),
        .req_ready_i   (req_ready_i),
        .req_op_o      (req_op_o),
        .req_addr_o    (req_addr_o),
        .req_data_o    (req_data_o),
        .req_x_o       (req_x_o),
        .req_y_o       (req_y_o),
        .req_load_id_o (req_load_id_o),
        .resp_v_i      (resp_v_i),
        .resp_data_i   (resp_data_i),
        .resp_load_id_i(resp_load_id_i),
        .finish_o      (finish_o),
        .error_o       (error_o)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        logic          op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IDW-1:0] id;
    } req_t;

    typedef struct {
        logic [IDW-1:0] tag;
        logic [DW-1:0]  data;
        int             due;
    } rsp_t;

    req_t        exp_q[$];
    rsp_t        pend_q[$];
    logic [DW-1:0] mem [N];

    int n_checks = 0;
    int n_errors = 0;

    int ready_mode   = 0;
    int resp_delay   = 1;
    int lifo         = 0;
    int corrupt_addr = -1;
    bit stray_req    = 1'b0;

    int  cyc = 0;
    int  inflight = 0;
    int  loads_done = 0;
    int  rsp_valid = 0;
    int  max_inflight = 0;
    bit  exp_error = 1'b0;
    bit  exp_finish = 1'b0;
    bit  err_pend = 1'b0;
    bit  fin_pend = 1'b0;
    bit  prev_stall = 1'b0;
    logic [57:0] prev_fields;
    logic [57:0] cur_fields;
    bit   xfer;
    bit   rsp_take;
    bit   bad;
    bit   have_rsp;
    rsp_t r;
    req_t e;
    int   idx;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Remote tile + scoreboard: drives ready/responses and checks every request at the negedge.
    initial begin
        req_ready_i    = 1'b0;
        resp_v_i       = 1'b0;
        resp_data_i    = '0;
        resp_load_id_i = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (reset_i) begin
                exp_q.delete();
                pend_q.delete();
                inflight = 0; loads_done = 0; rsp_valid = 0; max_inflight = 0;
                exp_error = 1'b0; exp_finish = 1'b0; err_pend = 1'b0; fin_pend = 1'b0;
                prev_stall = 1'b0;
                resp_v_i = 1'b0;
                req_ready_i = 1'b0;
            end else begin
                if (err_pend) exp_error = 1'b1;
                if (fin_pend) exp_finish = 1'b1;
                err_pend = 1'b0;
                fin_pend = 1'b0;
                check_output("error_o", error_o, exp_error);
                check_output("finish_o", finish_o, exp_finish);
                if (inflight >= MAX_OUT)
                    check_output("req_v_o at max outstanding", req_v_o, 0);

                cur_fields = {req_op_o, req_addr_o, req_data_o, req_load_id_o, req_x_o, req_y_o};
                if (prev_stall) begin
                    check_output("req_v_o held while stalled", req_v_o, 1);
                    check_output("req fields held while stalled", cur_fields, prev_fields);
                end

                req_ready_i = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);

                resp_v_i = 1'b0;
                resp_data_i = '0;
                resp_load_id_i = '0;
                have_rsp = 1'b0;
                if (stray_req) begin
                    stray_req = 1'b0;
                    r.tag = IDW'(3);
                    r.data = DW'(3) ^ SEED;
                    have_rsp = 1'b1;
                end else if (pend_q.size() > 0) begin
                    if (lifo != 0) begin
                        if ((pend_q.size() >= MAX_OUT || loads_done == N) && cyc >= pend_q[$].due) begin
                            r = pend_q.pop_back();
                            have_rsp = 1'b1;
                        end
                    end else if (cyc >= pend_q[0].due) begin
                        r = pend_q.pop_front();
                        have_rsp = 1'b1;
                    end
                end

                rsp_take = 1'b0;
                if (have_rsp) begin
                    resp_v_i = 1'b1;
                    resp_data_i = r.data;
                    resp_load_id_i = r.tag;
                    bad = (inflight == 0) || (int'(r.tag) >= N) ||
                          (r.data != (DW'(r.tag) ^ SEED));
                    if (bad) err_pend = 1'b1;
                    rsp_take = (inflight > 0);
                    if (rsp_take) begin
                        rsp_valid++;
                        if (rsp_valid == N) fin_pend = 1'b1;
                    end
                end

                xfer = req_v_o && req_ready_i;
                if (xfer) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected request", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("req_op_o", req_op_o, e.op);
                        check_output("req_addr_o", req_addr_o, e.addr);
                        check_output("req_data_o", req_data_o, e.data);
                        check_output("req_x_o/req_y_o", {req_x_o, req_y_o}, 4'b0101);
                        if (e.op) check_output("req_load_id_o", req_load_id_o, e.id);
                    end
                    idx = int'(req_addr_o);
                    if (!req_op_o) begin
                        if (idx < N) mem[idx] = req_data_o;
                    end else begin
                        r.tag = req_load_id_o;
                        r.data = (idx < N) ? mem[idx] : '0;
                        if (idx == corrupt_addr) r.data[0] = ~r.data[0];
                        r.due = cyc + resp_delay;
                        pend_q.push_back(r);
                        loads_done++;
                    end
                end
                inflight = inflight + ((xfer && req_op_o) ? 1 : 0) - (rsp_take ? 1 : 0);
                if (inflight > max_inflight) max_inflight = inflight;
                prev_stall = req_v_o && !req_ready_i;
                prev_fields = cur_fields;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        check_output("async reset req_v_o", req_v_o, 0);
        check_output("async reset finish_o", finish_o, 0);
        check_output("async reset error_o", error_o, 0);
        repeat (2) @(negedge clk_i);
        #3 reset_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic configure(input int rmode, input int dly, input int lf, input int corrupt);
        ready_mode   = rmode;
        resp_delay   = dly;
        lifo         = lf;
        corrupt_addr = corrupt;
        for (int a = 0; a < N; a++) begin
            exp_q.push_back('{op: 1'b0, addr: AW'(a), data: DW'(a) ^ SEED, id: IDW'(a)});
        end
        for (int a = 0; a < N; a++) begin
            exp_q.push_back('{op: 1'b1, addr: AW'(a), data: '0, id: IDW'(a)});
        end
        en_i = 1'b1;
        @(negedge clk_i);
        en_i = 1'b0;
        check_output("req_v_o one cycle after en_i", req_v_o, 1);
    endtask

    task automatic apply_stimulus(input string name, input int rmode, input int dly,
                                  input int lf, input int corrupt, input bit exp_err);
        int waited;
        $display("[TB] scenario: %s", name);
        configure(rmode, dly, lf, corrupt);
        waited = 0;
        while (!finish_o && waited < 3000) begin
            @(negedge clk_i);
            waited++;
        end
        check_output({name, " finish within budget"}, finish_o, 1);
        en_i = 1'b1;
        @(negedge clk_i);
        en_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_output({name, " finish_o sticky"}, finish_o, 1);
        check_output({name, " error_o at end"}, error_o, exp_err);
        check_output({name, " requests left"}, exp_q.size(), 0);
        check_output({name, " loads issued"}, loads_done, N);
        if (dly >= 20) check_output({name, " peak outstanding"}, max_inflight, MAX_OUT);
        apply_reset();
    endtask

    initial begin
        int waited;
        reset_i = 1'b1;
        en_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        #3 reset_i = 1'b0;
        @(negedge clk_i);
        check_output("reset req_v_o", req_v_o, 0);
        check_output("reset finish_o", finish_o, 0);
        check_output("reset error_o", error_o, 0);

        apply_stimulus("in-order echo", 0, 1, 0, -1, 1'b0);
        apply_stimulus("ready 1-of-3", 1, 1, 0, -1, 1'b0);
        apply_stimulus("delay 20", 0, 20, 0, -1, 1'b0);
        apply_stimulus("reverse order", 0, 2, 1, -1, 1'b0);
        apply_stimulus("corrupt word 5", 0, 1, 0, 5, 1'b1);
        apply_stimulus("random mix", int'($urandom_range(0, 1)), int'($urandom_range(1, 8)),
                       int'($urandom_range(0, 1)), -1, 1'b0);

        $display("[TB] scenario: reset during LOAD");
        configure(0, 20, 0, -1);
        waited = 0;
        while (!(req_v_o && req_op_o) && waited < 500) begin
            @(negedge clk_i);
            waited++;
        end
        check_output("reached LOAD", req_op_o, 1);
        repeat (3) @(negedge clk_i);
        apply_reset();
        stray_req = 1'b1;
        repeat (3) @(negedge clk_i);
        check_output("stray response in IDLE sets error_o", error_o, 1);
        apply_reset();
        apply_stimulus("restart after reset", 0, int'($urandom_range(1, 5)), 0, -1, 1'b0);

        $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
